// File: rtl/z80_bus_arbiter.sv
// -----------------------------------------------------------------------------
// z80_bus_arbiter
//
// Round-robin bus arbiter for MASTER_QTY masters (Z80 CPU, DMA, debug loader)
// sharing one Z80 master bus. Ownership changes only at a bus-cycle boundary
// (cycle_done high), and every handover is separated by TURN_CYCLES+1 dead
// cycles with no grant: TURN_CYCLES in TURN plus one IDLE arbitration cycle.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   Defined   : an owner that keeps the bus for TIMEOUT_CYCLES cycles while
//               another master is waiting is forced off at the next cycle
//               boundary; timeout_evt pulses for one cycle.
//   Undefined : no timeout counter, timeout_evt tied low, grants are held for
//               as long as the owner requests.
//
// Ports
//   clk          in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   req          in   [MASTER_QTY] level request per master
//   cycle_done   in   current bus transaction complete; handover allowed
//   gnt          out  [MASTER_QTY] one-hot grant or all-zero
//   msel         out  [clog2(MASTER_QTY)] current / most recent owner index
//   bus_busy     out  |gnt
//   timeout_evt  out  one-cycle pulse on forced release
//   dbg_state    out  [2] FSM state (0 IDLE, 1 GRANT, 2 TURN)
//
// Handshake: req is a level. A master owns the bus exactly while its gnt bit
// is high. It gives the bus back by dropping req; the grant is removed on the
// first rising edge at which req[owner]=0 and cycle_done=1 are both sampled.
// Requests from other masters never disturb an existing grant.
// -----------------------------------------------------------------------------
module z80_bus_arbiter #(
  parameter int MASTER_QTY     = 2,
  parameter int TURN_CYCLES    = 1,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int SEL_W         = (MASTER_QTY > 1) ? $clog2(MASTER_QTY) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [MASTER_QTY-1:0] req,
  input  logic                  cycle_done,
  output logic [MASTER_QTY-1:0] gnt,
  output logic [SEL_W-1:0]      msel,
  output logic                  bus_busy,
  output logic                  timeout_evt,
  output logic [1:0]            dbg_state
);

  // Elaboration-time parameter range guard.
  if (MASTER_QTY < 2 || MASTER_QTY > 8 || TURN_CYCLES < 1 || TURN_CYCLES > 15 ||
      TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
    $error("z80_bus_arbiter: parameter out of legal range");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  localparam logic [SEL_W:0] QTY_W     = (SEL_W+1)'(MASTER_QTY);
  localparam logic [3:0]     TURN_INIT = 4'(TURN_CYCLES - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [SEL_W-1:0]    r_msel;
  logic [SEL_W-1:0]    w_msel_nxt;
  logic [SEL_W-1:0]    r_ptr;
  logic [SEL_W-1:0]    w_ptr_nxt;
  logic [3:0]          r_turn_cnt;
  logic [3:0]          w_turn_cnt_nxt;
  logic                w_enter_grant;

  logic [MASTER_QTY-1:0]   w_gnt;
  logic                    w_owner_req;
  logic                    w_force;
  logic [2*MASTER_QTY-1:0] w_req_dbl;
  logic [MASTER_QTY-1:0]   w_req_rot;
  logic [SEL_W-1:0]        w_off;
  logic [SEL_W:0]          w_sum;
  logic [SEL_W-1:0]        w_win;
  logic [SEL_W:0]          w_pinc;
  logic [SEL_W-1:0]        w_ptr_after;

  // Grant is decoded from state and owner index, both asynchronously reset,
  // so an asserted reset_n removes the grant without waiting for a clock.
  always_comb begin
    w_gnt = '0;
    if (r_state == ST_GRANT) begin
      w_gnt = {{(MASTER_QTY-1){1'b0}}, 1'b1} << r_msel;
    end
  end

  assign w_owner_req = |(req & w_gnt);

  // Round-robin search: rotate req so the pointer position lands at bit 0,
  // take the lowest set bit, then rotate the offset back into an index.
  always_comb begin
    w_req_dbl = {req, req} >> r_ptr;
    w_req_rot = w_req_dbl[MASTER_QTY-1:0];
    w_off     = '0;
    for (int i = MASTER_QTY - 1; i >= 0; i--) begin
      if (w_req_rot[i]) w_off = SEL_W'(i);
    end
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    if (w_sum >= QTY_W) w_sum = w_sum - QTY_W;
    w_win  = w_sum[SEL_W-1:0];
    w_pinc = {1'b0, w_win} + 1'b1;
    if (w_pinc >= QTY_W) w_pinc = '0;
    w_ptr_after = w_pinc[SEL_W-1:0];
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_wait_cnt;
  logic        r_timeout_evt;
  logic        w_others_wait;

  assign w_others_wait = |(req & ~w_gnt);
  assign w_force       = (r_state == ST_GRANT) && (r_wait_cnt >= TO_LIMIT) && cycle_done;

  // Counts grant cycles during which some other master is waiting.
  // Saturates so a bus stuck without cycle_done cannot wrap the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wait_cnt    <= '0;
      r_timeout_evt <= 1'b0;
    end else begin
      r_timeout_evt <= w_force;
      if (w_enter_grant) begin
        r_wait_cnt <= '0;
      end else if (r_state == ST_GRANT && w_others_wait && r_wait_cnt != 16'hFFFF) begin
        r_wait_cnt <= r_wait_cnt + 16'd1;
      end
    end
  end

  assign timeout_evt = r_timeout_evt;
`else
  assign w_force     = 1'b0;
  assign timeout_evt = 1'b0;
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_msel_nxt     = r_msel;
    w_ptr_nxt      = r_ptr;
    w_turn_cnt_nxt = r_turn_cnt;
    w_enter_grant  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|req) begin
          w_state_nxt   = ST_GRANT;
          w_msel_nxt    = w_win;
          w_ptr_nxt     = w_ptr_after;
          w_enter_grant = 1'b1;
        end
      end
      ST_GRANT: begin
        // A low req with cycle_done low is a drain: keep the grant.
        if ((!w_owner_req && cycle_done) || w_force) begin
          w_state_nxt    = ST_TURN;
          w_turn_cnt_nxt = TURN_INIT;
        end
      end
      ST_TURN: begin
        // msel is left alone so the bus mux stays on the last owner.
        if (r_turn_cnt == 4'd0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_turn_cnt_nxt = r_turn_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_msel     <= '0;
      r_ptr      <= '0;
      r_turn_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_msel     <= w_msel_nxt;
      r_ptr      <= w_ptr_nxt;
      r_turn_cnt <= w_turn_cnt_nxt;
    end
  end

  assign gnt       = w_gnt;
  assign msel      = r_msel;
  assign bus_busy  = |w_gnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_z80_bus_arbiter.sv
module tb_z80_bus_arbiter;

  localparam int MQ   = 3;
  localparam int TURN = 1;
  localparam int TO   = 8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] req;
  logic       cycle_done;
  logic [2:0] gnt;
  logic [1:0] msel;
  logic       bus_busy;
  logic       timeout_evt;
  logic [1:0] dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int   m_owner;
  int   m_dead;
  int   m_ptr;
  int   m_msel;
  int   m_wait;
  logic m_evt;

  z80_bus_arbiter #(
    .MASTER_QTY    (MQ),
    .TURN_CYCLES   (TURN),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .cycle_done (cycle_done),
    .gnt        (gnt),
    .msel       (msel),
    .bus_busy   (bus_busy),
    .timeout_evt(timeout_evt),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    req        = 3'b000;
    cycle_done = 1'b1;
    step();
    step();
    reset_n = 1'b1;
  endtask

  // Reference model: one call describes what the bus looks like after the
  // next rising edge given the inputs presented to it.
  task automatic model_reset();
    m_owner = -1;
    m_dead  = 0;
    m_ptr   = 0;
    m_msel  = 0;
    m_wait  = 0;
    m_evt   = 1'b0;
  endtask

  task automatic model_step(input logic [2:0] rq, input logic cd);
    logic force_rel;
    logic found;
    int   c;
    m_evt     = 1'b0;
    force_rel = 1'b0;
    if (m_owner >= 0) begin
`ifdef ARB_TIMEOUT_EN
      force_rel = (m_wait >= TO - 1) && cd;
`endif
      if ((!rq[m_owner[1:0]] && cd) || force_rel) begin
        m_owner = -1;
        m_dead  = TURN;
        m_evt   = force_rel;
      end else if ((rq & ~(3'b001 << m_owner)) != 3'b000) begin
        m_wait++;
      end
    end else if (m_dead > 0) begin
      m_dead--;
    end else if (rq != 3'b000) begin
      found = 1'b0;
      for (int k = 0; k < MQ; k++) begin
        c = (m_ptr + k) % MQ;
        if (!found && rq[c[1:0]]) begin
          found   = 1'b1;
          m_owner = c;
        end
      end
      m_msel = m_owner;
      m_ptr  = (m_owner + 1) % MQ;
      m_wait = 0;
    end
  endtask

  function automatic logic [2:0] model_gnt();
    return (m_owner >= 0) ? (3'b001 << m_owner) : 3'b000;
  endfunction

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset_n    = 1'b0;
    req        = 3'b111;
    cycle_done = 1'b1;
    step();
    step();
    n_tests++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL reset_gnt: got %b want 000", gnt); end
    n_tests++; if (msel !== 2'd0) begin n_fail++; $display("FAIL reset_msel: got %0d want 0", msel); end
    n_tests++; if (bus_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus_busy); end
    n_tests++; if (timeout_evt !== 1'b0) begin n_fail++; $display("FAIL reset_evt: got %b want 0", timeout_evt); end
    reset_n = 1'b1;
    step();
    n_tests++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL reset_first_gnt: got %b want 001", gnt); end
  endtask

  task automatic test_single();
    do_reset();
    req = 3'b010;
    step();
    n_tests++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL single_gnt: got %b want 010", gnt); end
    n_tests++; if (msel !== 2'd1) begin n_fail++; $display("FAIL single_msel: got %0d want 1", msel); end
    n_tests++; if (bus_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", bus_busy); end
    req = 3'b000;
    step();
    n_tests++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL single_release: got %b want 000", gnt); end
    n_tests++; if (msel !== 2'd1) begin n_fail++; $display("FAIL single_msel_hold: got %0d want 1", msel); end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_seq [4];
    int prev;
    int zeros;
    exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001};
    do_reset();
    req  = 3'b111;
    prev = -1;
    for (int k = 0; k < 4; k++) begin
      zeros = 0;
      step();
      req = 3'b111;
      while (gnt === 3'b000 && zeros < 8) begin
        zeros++;
        n_tests++;
        if (msel !== prev[1:0]) begin n_fail++; $display("FAIL rr_dead_msel: got %0d want %0d", msel, prev); end
        step();
      end
      n_tests++; if (gnt !== exp_seq[k]) begin n_fail++; $display("FAIL rr_order[%0d]: got %b want %b", k, gnt, exp_seq[k]); end
      if (k > 0) begin
        n_tests++; if (zeros != 2) begin n_fail++; $display("FAIL rr_dead_cycles[%0d]: got %0d want 2", k, zeros); end
      end
      prev = k % MQ;
      req  = 3'b111 & ~exp_seq[k];
    end
    req = 3'b000;
  endtask

  task automatic test_drain();
    do_reset();
    req = 3'b001;
    step();
    n_tests++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL drain_grant: got %b want 001", gnt); end
    req        = 3'b000;
    cycle_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL drain_hold[%0d]: got %b want 001", i, gnt); end
    end
    cycle_done = 1'b1;
    step();
    n_tests++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL drain_release: got %b want 000", gnt); end
  endtask

  task automatic test_async_reset();
    logic [2:0] first_req [2];
    first_req = '{3'b100, 3'b010};
    for (int v = 0; v < 2; v++) begin
      do_reset();
      req = first_req[v];
      step();
      n_tests++; if (gnt !== first_req[v]) begin n_fail++; $display("FAIL areset_pre[%0d]: got %b want %b", v, gnt, first_req[v]); end
      #3;
      reset_n = 1'b0;
      #1;
      n_tests++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL areset_gnt[%0d]: got %b want 000", v, gnt); end
      n_tests++; if (bus_busy !== 1'b0) begin n_fail++; $display("FAIL areset_busy[%0d]: got %b want 0", v, bus_busy); end
      req = 3'b101;
      step();
      step();
      reset_n = 1'b1;
      step();
      n_tests++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL areset_ptr[%0d]: got %b want 001", v, gnt); end
    end
    req = 3'b000;
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    int pulses;
    do_reset();
    req = 3'b011;
    step();
    n_tests++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL to_grant: got %b want 001", gnt); end
    for (int i = 1; i < TO; i++) begin
      step();
      n_tests++; if (gnt !== 3'b001 || timeout_evt !== 1'b0) begin
        n_fail++; $display("FAIL to_hold[%0d]: got gnt=%b evt=%b want 001/0", i, gnt, timeout_evt);
      end
    end
    step();
    n_tests++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL to_release: got %b want 000", gnt); end
    pulses = 0;
    if (timeout_evt === 1'b1) pulses++;
    step();
    if (timeout_evt === 1'b1) pulses++;
    n_tests++; if (pulses != 1) begin n_fail++; $display("FAIL to_pulse: got %0d pulses want 1", pulses); end
    step();
    n_tests++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL to_next_owner: got %b want 010", gnt); end
    req = 3'b000;
  endtask
`else
  task automatic test_hold();
    do_reset();
    req = 3'b011;
    step();
    for (int i = 0; i < 4 * TO; i++) begin
      step();
      n_tests++; if (gnt !== 3'b001 || timeout_evt !== 1'b0) begin
        n_fail++; $display("FAIL hold[%0d]: got gnt=%b evt=%b want 001/0", i, gnt, timeout_evt);
      end
    end
    req = 3'b000;
  endtask
`endif

  task automatic test_random();
    logic [2:0] r_req;
    logic [2:0] exp_g;
    do_reset();
    model_reset();
    r_req = 3'b000;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int b = 0; b < MQ; b++) begin
        if ($urandom_range(0, 3) == 0) r_req[b] = ~r_req[b];
      end
      req        = r_req;
      cycle_done = ($urandom_range(0, 3) != 0);
      model_step(req, cycle_done);
      step();
      exp_g = model_gnt();
      n_tests++; if (gnt !== exp_g) begin n_fail++; $display("FAIL rand_gnt@%0d: got %b want %b", cyc, gnt, exp_g); end
      n_tests++; if (msel !== m_msel[1:0]) begin n_fail++; $display("FAIL rand_msel@%0d: got %0d want %0d", cyc, msel, m_msel); end
      n_tests++; if (bus_busy !== (exp_g != 3'b000)) begin n_fail++; $display("FAIL rand_busy@%0d: got %b want %b", cyc, bus_busy, exp_g != 3'b000); end
      n_tests++; if (timeout_evt !== m_evt) begin n_fail++; $display("FAIL rand_evt@%0d: got %b want %b", cyc, timeout_evt, m_evt); end
      n_tests++; if (!$onehot0(gnt)) begin n_fail++; $display("FAIL rand_onehot@%0d: got %b want at most one bit", cyc, gnt); end
    end
    req        = 3'b000;
    cycle_done = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_drain();
    test_async_reset();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`else
    test_hold();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
